mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the RV32 core, directly downstream of the execute stage. Takes the execute result (effective address or ALU value), store data and write-back control. Performs byte/half/word loads and stores over a req/ack data-memory port. Produces the registered write-back bundle and stalls the upstream pipeline while a memory access is outstanding.

## Interface
- ACK_TIMEOUT, 15: BUSY cycles without `i_dmem_ack` before the access is aborted (1..255).
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  execute stage presents an instruction
- i_ALUOutput  in  32  effective address (load/store) or result (other ops)
- i_rd2  in  32  store data
- i_write_reg  in  5  destination register
- i_MemRead / i_MemWrite  in  1/1  load / store (never both)
- i_func3  in  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
- i_RegWrite  in  1  instruction writes rd
- o_stall  out  1  hold execute stage (combinational)
- o_dmem_req, o_dmem_we  out  1/1  request, write
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ack  in  1  access complete (single-cycle pulse)
- i_dmem_rdata  in  32  read word, valid with ack
- o_wb_valid  out  1  write-back bundle valid (1-cycle pulse per instruction)
- o_wb_data  out  32  load data or passed-through result
- o_wb_write_reg  out  5  destination register
- o_wb_RegWrite  out  1  commit write
- o_bus_err  out  1  timeout abort, coincident with o_wb_valid
- o_misaligned  out  1  misaligned abort (macro-dependent), coincident with o_wb_valid

## Operation
- Instruction consumed at the edge where i_valid=1 and o_stall=0.
- FSM states IDLE and BUSY.
- IDLE, non-memory op: consumed; next cycle o_wb_valid=1, o_wb_data=i_ALUOutput, control copied.
- IDLE, memory op: o_stall=1 that cycle. Address, data, func3, rd and RegWrite are latched; go to BUSY. o_dmem_req=1 from the next cycle.
- BUSY: req/we/addr/be/wdata held stable. o_stall=1 except in the ack cycle. Ack → IDLE; next cycle o_wb_valid=1 with load data (load) or RegWrite=0 (store). Request deasserts at the same edge.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{rd2[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{rd2[15:0]}}.
  - SW: be=1111.
  - Loads drive be=1111.
- Load extract: select byte via addr[1:0], or halfword via addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
- Timeout: counter cleared on entering BUSY and incremented each BUSY cycle without ack. At ACK_TIMEOUT: req dropped, o_stall=0 that cycle, → IDLE, wb pulse with RegWrite=0 and o_bus_err=1.
- Ack and timeout in the same cycle: ack wins.
- Ack while IDLE: ignored.

## Timing
- Reset: state IDLE, counter 0. All outputs 0, including o_stall (when i_valid=0).
- Non-memory latency: 1 cycle; one instruction per cycle throughput.
- Memory latency: accept at cycle 0, req at cycle 1, ack at cycle 1+w, o_wb_valid at cycle 2+w. Minimum 2 cycles.
- i_reset mid-BUSY: at that edge → IDLE, req=0 next cycle, no wb pulse. A pending ack is discarded.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned access is never issued to memory.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Consumed in IDLE (no stall). Next cycle: wb pulse, RegWrite=0, o_misaligned=1.
- MISALIGN_TRAP_EN undefined: o_misaligned tied 0. Low address bits are ignored (half uses addr[1], word uses lane 0) and the access proceeds normally.

## Structure
- Shared package PipelineReg:
  - MEM_STATE fields MemRead, MemWrite, func3.
  - New WB_STATE struct (data, write_reg, RegWrite, valid).
  - func3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
- Sub-module dmem_lane (combinational): store be/wdata formation, load extract/extend, misalign detect. FSM, timeout counter and WB register stay in mem_stage.

## Test plan
- ADD result 0x0000_1234, RegWrite=1, rd=5 → next cycle wb_valid, data 0x1234, rd 5, no req, no stall.
- SB addr 0x103, rd2 0xAABBCCDD, ack after 3 waits → be 1000, wdata 0xDDDDDDDD, addr 0x100, stall 4 cycles, wb RegWrite=0.
- LB addr 0x202, rdata 0x0080_0000, zero-wait ack → wb_data 0xFFFF_FF80. Same with LBU → 0x0000_0080.
- LH addr 0x102, rdata 0x8001_0000 → 0xFFFF_8001. LW addr 0x101:
  - Macro defined → no req, o_misaligned=1.
  - Macro undefined → req at 0x100.
- No ack, ACK_TIMEOUT=15 → req high exactly 15 cycles, o_bus_err pulse, RegWrite=0, next instruction accepted.
- i_reset during BUSY, then ack 1 cycle later → req=0, no wb pulse, ack ignored, FSM IDLE.

Source files
------------

// File: rtl/PipelineReg.sv
// PipelineReg: types and constants shared by the pipeline stages of the RV32 core.
//   MEM_STATE - memory-access control carried into the mem stage (MemRead, MemWrite, func3)
//   WB_STATE  - registered write-back bundle (data, write_reg, RegWrite, valid)
//   F3_*      - func3 size/sign encodings for loads and stores
package PipelineReg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef struct packed {
      logic       MemRead;
      logic       MemWrite;
      logic [2:0] func3;
   } MEM_STATE;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  write_reg;
      logic        RegWrite;
      logic        valid;
   } WB_STATE;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane logic for the mem stage.
//   func3_i      - size/sign of the access
//   is_store_i   - access is a store (loads always enable all four lanes)
//   addr_lo_i    - low two bits of the effective address
//   store_data_i - raw store data (rs2)
//   rdata_i      - word returned by data memory
//   be_o         - byte enables
//   wdata_o      - lane-replicated store data
//   load_data_o  - extracted and sign/zero-extended load result
//   misaligned_o - access is misaligned (only when MISALIGN_TRAP_EN is defined)
module dmem_lane
   import PipelineReg::*;
(
   input  logic [2:0]  func3_i,
   input  logic        is_store_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misaligned_o
`endif
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store lane formation; func3[1:0] carries the size for stores.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = store_data_i;
      if (is_store_i) begin
         case (func3_i[1:0])
            2'b00: begin
               be_o    = 4'b0001 << addr_lo_i;
               wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
               be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
               be_o    = 4'b1111;
               wdata_o = store_data_i;
            end
         endcase
      end
   end

   // Load extraction: byte by addr[1:0], halfword by addr[1]; addr[0] is ignored for halves.
   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (func3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_o = {24'd0, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_o = {16'd0, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   // H/HU share func3[1:0]=01; W is 10.
   always_comb begin
      misaligned_o = 1'b0;
      if (func3_i[1:0] == 2'b01) begin
         misaligned_o = addr_lo_i[0];
      end else if (func3_i[1:0] == 2'b10) begin
         misaligned_o = (addr_lo_i != 2'b00);
      end
   end
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32 pipeline, downstream of execute.
// Non-memory ops pass straight to the write-back register; loads/stores are issued on a
// req/ack data-memory port while the execute stage is stalled.
// Optional feature: MISALIGN_TRAP_EN (misaligned accesses are trapped instead of issued).
//   i_clk, i_reset      - clock, synchronous active-high reset
//   i_valid ... i_RegWrite - instruction from execute (address/result, store data, control)
//   o_stall             - hold execute stage (combinational)
//   o_dmem_*/i_dmem_*   - data-memory request/response port
//   o_wb_*              - registered write-back bundle
//   o_bus_err           - ack timeout abort, with o_wb_valid
//   o_misaligned        - misaligned abort, with o_wb_valid
module mem_stage
   import PipelineReg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_valid,
   input  logic [31:0] i_ALUOutput,
   input  logic [31:0] i_rd2,
   input  logic [4:0]  i_write_reg,
   input  logic        i_MemRead,
   input  logic        i_MemWrite,
   input  logic [2:0]  i_func3,
   input  logic        i_RegWrite,
   output logic        o_stall,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_be,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_wb_valid,
   output logic [31:0] o_wb_data,
   output logic [4:0]  o_wb_write_reg,
   output logic        o_wb_RegWrite,
   output logic        o_bus_err,
   output logic        o_misaligned
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [7:0] TimeoutCnt = 8'(ACK_TIMEOUT);

   logic [0:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   MEM_STATE    ctl_q, ctl_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        regwrite_q, regwrite_d;
   WB_STATE     wb_q, wb_d;
   logic        bus_err_q, bus_err_d;
   logic        misaligned_q, misaligned_d;

   logic        busy;
   logic        is_mem;
   logic        trap;
   logic        timeout_hit;
   logic [2:0]  lane_func3;
   logic [1:0]  lane_addr_lo;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_load_data;

   assign busy   = (state_q == ST_BUSY);
   assign is_mem = i_MemRead | i_MemWrite;

   // In IDLE the lane logic looks at the incoming op (for misalign detect);
   // in BUSY it looks at the latched access.
   assign lane_func3   = busy ? ctl_q.func3 : i_func3;
   assign lane_addr_lo = busy ? addr_q[1:0] : i_ALUOutput[1:0];

   dmem_lane u_dmem_lane (
      .func3_i      (lane_func3),
      .is_store_i   (ctl_q.MemWrite),
      .addr_lo_i    (lane_addr_lo),
      .store_data_i (sdata_q),
      .rdata_i      (i_dmem_rdata),
      .be_o         (lane_be),
      .wdata_o      (lane_wdata),
      .load_data_o  (lane_load_data)
`ifdef MISALIGN_TRAP_EN
      ,
      .misaligned_o (trap)
`endif
   );

`ifndef MISALIGN_TRAP_EN
   assign trap = 1'b0;
`endif

   // Ack takes priority over an expiring timeout.
   assign timeout_hit = busy && !i_dmem_ack && (cnt_q == TimeoutCnt);

   always_comb begin
      if (busy) begin
         o_stall = !(i_dmem_ack || timeout_hit);
      end else begin
         o_stall = i_valid && is_mem && !trap;
      end
   end

   assign o_dmem_req   = busy && !timeout_hit;
   assign o_dmem_we    = o_dmem_req && ctl_q.MemWrite;
   assign o_dmem_addr  = o_dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign o_dmem_wdata = o_dmem_req ? lane_wdata : 32'd0;
   assign o_dmem_be    = o_dmem_req ? lane_be : 4'd0;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ctl_d        = ctl_q;
      addr_d       = addr_q;
      sdata_d      = sdata_q;
      rd_d         = rd_q;
      regwrite_d   = regwrite_q;
      wb_d         = '0;
      bus_err_d    = 1'b0;
      misaligned_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               if (!is_mem) begin
                  wb_d.data      = i_ALUOutput;
                  wb_d.write_reg = i_write_reg;
                  wb_d.RegWrite  = i_RegWrite;
                  wb_d.valid     = 1'b1;
               end else if (trap) begin
                  // Faulting address is reported in the data field.
                  wb_d.data      = i_ALUOutput;
                  wb_d.write_reg = i_write_reg;
                  wb_d.valid     = 1'b1;
                  misaligned_d   = 1'b1;
               end else begin
                  ctl_d.MemRead  = i_MemRead;
                  ctl_d.MemWrite = i_MemWrite;
                  ctl_d.func3    = i_func3;
                  addr_d         = i_ALUOutput;
                  sdata_d        = i_rd2;
                  rd_d           = i_write_reg;
                  regwrite_d     = i_RegWrite;
                  cnt_d          = 8'd0;
                  state_d        = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (i_dmem_ack) begin
               wb_d.data      = ctl_q.MemRead ? lane_load_data : 32'd0;
               wb_d.write_reg = rd_q;
               wb_d.RegWrite  = regwrite_q && ctl_q.MemRead;
               wb_d.valid     = 1'b1;
               state_d        = ST_IDLE;
            end else if (timeout_hit) begin
               wb_d.write_reg = rd_q;
               wb_d.valid     = 1'b1;
               bus_err_d      = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         ctl_q        <= '0;
         addr_q       <= 32'd0;
         sdata_q      <= 32'd0;
         rd_q         <= 5'd0;
         regwrite_q   <= 1'b0;
         wb_q         <= '0;
         bus_err_q    <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ctl_q        <= ctl_d;
         addr_q       <= addr_d;
         sdata_q      <= sdata_d;
         rd_q         <= rd_d;
         regwrite_q   <= regwrite_d;
         wb_q         <= wb_d;
         bus_err_q    <= bus_err_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign o_wb_valid     = wb_q.valid;
   assign o_wb_data      = wb_q.data;
   assign o_wb_write_reg = wb_q.write_reg;
   assign o_wb_RegWrite  = wb_q.RegWrite;
   assign o_bus_err      = bus_err_q;
   assign o_misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_ALUOutput = '0;
   logic [31:0] i_rd2 = '0;
   logic [4:0]  i_write_reg = '0;
   logic        i_MemRead = 1'b0;
   logic        i_MemWrite = 1'b0;
   logic [2:0]  i_func3 = '0;
   logic        i_RegWrite = 1'b0;
   logic        i_dmem_ack = 1'b0;
   logic [31:0] i_dmem_rdata = '0;
   logic        o_stall, o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
   logic [3:0]  o_dmem_be;
   logic        o_wb_valid, o_wb_RegWrite, o_bus_err, o_misaligned;
   logic [4:0]  o_wb_write_reg;

   int total = 0;
   int bad = 0;

   mem_stage #(.ACK_TIMEOUT(15)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_valid        (i_valid),
      .i_ALUOutput    (i_ALUOutput),
      .i_rd2          (i_rd2),
      .i_write_reg    (i_write_reg),
      .i_MemRead      (i_MemRead),
      .i_MemWrite     (i_MemWrite),
      .i_func3        (i_func3),
      .i_RegWrite     (i_RegWrite),
      .o_stall        (o_stall),
      .o_dmem_req     (o_dmem_req),
      .o_dmem_we      (o_dmem_we),
      .o_dmem_addr    (o_dmem_addr),
      .o_dmem_wdata   (o_dmem_wdata),
      .o_dmem_be      (o_dmem_be),
      .i_dmem_ack     (i_dmem_ack),
      .i_dmem_rdata   (i_dmem_rdata),
      .o_wb_valid     (o_wb_valid),
      .o_wb_data      (o_wb_data),
      .o_wb_write_reg (o_wb_write_reg),
      .o_wb_RegWrite  (o_wb_RegWrite),
      .o_bus_err      (o_bus_err),
      .o_misaligned   (o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input logic rdn, input logic wr,
                        input logic [2:0] f3, input logic rw);
      i_valid = v; i_ALUOutput = a; i_rd2 = d; i_write_reg = rd;
      i_MemRead = rdn; i_MemWrite = wr; i_func3 = f3; i_RegWrite = rw;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
      tick(); tick();
      i_reset = 1'b0;
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", o_stall); end
      total++; if (o_dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", o_dmem_req); end
      total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got %b want 0", o_wb_valid); end
      total++; if (o_wb_data !== 32'h0) begin bad++; $display("FAIL reset_wb_data got %h want 0", o_wb_data); end
      total++; if ({o_bus_err, o_misaligned, o_dmem_be} !== 6'd0) begin
         bad++; $display("FAIL reset_misc got %b want 0", {o_bus_err, o_misaligned, o_dmem_be});
      end
   endtask

   task automatic test_alu();
      drive(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 3'd0, 1'b1);
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL alu_stall got %b want 0", o_stall); end
      total++; if (o_dmem_req !== 1'b0) begin bad++; $display("FAIL alu_req got %b want 0", o_dmem_req); end
      tick();
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data, o_wb_write_reg, o_wb_RegWrite} !== {1'b1, 32'h1234, 5'd5, 1'b1}) begin
         bad++; $display("FAIL alu_wb got %b/%h/%0d/%b want 1/00001234/5/1",
                         o_wb_valid, o_wb_data, o_wb_write_reg, o_wb_RegWrite);
      end
      tick();
      total++; if (o_wb_valid !== 1'b0) begin bad++; $display("FAIL alu_wb_pulse got %b want 0", o_wb_valid); end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'hA, 32'h0, 5'd1, 1'b0, 1'b0, 3'd0, 1'b1);
      tick();
      drive(1'b1, 32'hB, 32'h0, 5'd2, 1'b0, 1'b0, 3'd0, 1'b0);
      total++; if ({o_wb_valid, o_wb_data, o_wb_write_reg} !== {1'b1, 32'hA, 5'd1}) begin
         bad++; $display("FAIL b2b_first got %b/%h/%0d want 1/0000000a/1", o_wb_valid, o_wb_data, o_wb_write_reg);
      end
      tick();
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data, o_wb_write_reg, o_wb_RegWrite} !== {1'b1, 32'hB, 5'd2, 1'b0}) begin
         bad++; $display("FAIL b2b_second got %b/%h/%0d/%b want 1/0000000b/2/0",
                         o_wb_valid, o_wb_data, o_wb_write_reg, o_wb_RegWrite);
      end
      tick();
   endtask

   task automatic test_sb();
      int stalls = 0;
      drive(1'b1, 32'h0000_0103, 32'hAABB_CCDD, 5'd9, 1'b0, 1'b1, 3'd0, 1'b1);
      #1;
      total++; if (o_dmem_req !== 1'b0) begin bad++; $display("FAIL sb_req_cycle0 got %b want 0", o_dmem_req); end
      if (o_stall) stalls++;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (o_stall) stalls++;
         total++; if ({o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata} !==
                      {1'b1, 1'b1, 4'b1000, 32'h100, 32'hDDDD_DDDD}) begin
            bad++; $display("FAIL sb_bus got req=%b we=%b be=%b addr=%h wdata=%h want 1 1 1000 00000100 dddddddd",
                            o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata);
         end
         tick();
      end
      i_dmem_ack = 1'b1;
      #1;
      if (o_stall) stalls++;
      total++; if (o_dmem_req !== 1'b1) begin bad++; $display("FAIL sb_req_ack got %b want 1", o_dmem_req); end
      tick();
      i_dmem_ack = 1'b0;
      i_valid = 1'b0;
      total++; if (stalls !== 4) begin bad++; $display("FAIL sb_stall_cycles got %0d want 4", stalls); end
      total++; if ({o_wb_valid, o_wb_RegWrite, o_dmem_req, o_bus_err} !== 4'b1000) begin
         bad++; $display("FAIL sb_wb got valid=%b rw=%b req=%b err=%b want 1 0 0 0",
                         o_wb_valid, o_wb_RegWrite, o_dmem_req, o_bus_err);
      end
      tick();
   endtask

   task automatic test_load(input string name, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic [31:0] exp);
      drive(1'b1, a, 32'h0, 5'd3, 1'b1, 1'b0, f3, 1'b1);
      #1;
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL %s_stall got %b want 1", name, o_stall); end
      tick();
      i_dmem_ack = 1'b1;
      i_dmem_rdata = rdata;
      #1;
      total++; if ({o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_stall} !==
                   {1'b1, 1'b0, 4'b1111, {a[31:2], 2'b00}, 1'b0}) begin
         bad++; $display("FAIL %s_bus got req=%b we=%b be=%b addr=%h stall=%b want 1 0 1111 %h 0",
                         name, o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_stall, {a[31:2], 2'b00});
      end
      tick();
      i_dmem_ack = 1'b0;
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data, o_wb_RegWrite, o_wb_write_reg} !== {1'b1, exp, 1'b1, 5'd3}) begin
         bad++; $display("FAIL %s_wb got %b/%h/%b/%0d want 1/%h/1/3",
                         name, o_wb_valid, o_wb_data, o_wb_RegWrite, o_wb_write_reg, exp);
      end
      total++; if (o_dmem_req !== 1'b0) begin bad++; $display("FAIL %s_req_drop got %b want 0", name, o_dmem_req); end
      tick();
   endtask

   task automatic test_lw_misaligned();
      drive(1'b1, 32'h0000_0101, 32'h0, 5'd4, 1'b1, 1'b0, 3'd2, 1'b1);
      #1;
`ifdef MISALIGN_TRAP_EN
      total++; if ({o_stall, o_dmem_req} !== 2'b00) begin
         bad++; $display("FAIL mis_issue got stall=%b req=%b want 0 0", o_stall, o_dmem_req);
      end
      tick();
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_RegWrite, o_misaligned, o_dmem_req} !== 4'b1010) begin
         bad++; $display("FAIL mis_wb got valid=%b rw=%b mis=%b req=%b want 1 0 1 0",
                         o_wb_valid, o_wb_RegWrite, o_misaligned, o_dmem_req);
      end
      tick();
`else
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL mis_stall got %b want 1", o_stall); end
      tick();
      total++; if ({o_dmem_req, o_dmem_addr} !== {1'b1, 32'h100}) begin
         bad++; $display("FAIL mis_req got req=%b addr=%h want 1 00000100", o_dmem_req, o_dmem_addr);
      end
      i_dmem_ack = 1'b1;
      i_dmem_rdata = 32'h1122_3344;
      tick();
      i_dmem_ack = 1'b0;
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data, o_misaligned} !== {1'b1, 32'h1122_3344, 1'b0}) begin
         bad++; $display("FAIL mis_wb got %b/%h/%b want 1/11223344/0", o_wb_valid, o_wb_data, o_misaligned);
      end
      tick();
`endif
   endtask

   task automatic test_timeout();
      int reqs = 0;
      drive(1'b1, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b0, 3'd2, 1'b1);
      tick();
      for (int i = 0; i < 40 && o_dmem_req; i++) begin
         reqs++;
         tick();
      end
      total++; if (reqs !== 15) begin bad++; $display("FAIL to_req_cycles got %0d want 15", reqs); end
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL to_stall got %b want 0", o_stall); end
      tick();
      drive(1'b1, 32'h55, 32'h0, 5'd7, 1'b0, 1'b0, 3'd0, 1'b1);
      #1;
      total++; if ({o_wb_valid, o_bus_err, o_wb_RegWrite, o_wb_write_reg} !== {3'b110, 5'd6}) begin
         bad++; $display("FAIL to_wb got valid=%b err=%b rw=%b rd=%0d want 1 1 0 6",
                         o_wb_valid, o_bus_err, o_wb_RegWrite, o_wb_write_reg);
      end
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL to_next_stall got %b want 0", o_stall); end
      tick();
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data, o_bus_err, o_wb_write_reg} !== {1'b1, 32'h55, 1'b0, 5'd7}) begin
         bad++; $display("FAIL to_next_wb got %b/%h/%b/%0d want 1/00000055/0/7",
                         o_wb_valid, o_wb_data, o_bus_err, o_wb_write_reg);
      end
      tick();
   endtask

   task automatic test_ack_at_timeout();
      drive(1'b1, 32'h0000_0500, 32'h0, 5'd8, 1'b1, 1'b0, 3'd2, 1'b1);
      tick();
      for (int i = 0; i < 15; i++) tick();
      i_dmem_ack = 1'b1;
      i_dmem_rdata = 32'hCAFE_F00D;
      #1;
      total++; if ({o_dmem_req, o_stall} !== 2'b10) begin
         bad++; $display("FAIL ackto_bus got req=%b stall=%b want 1 0", o_dmem_req, o_stall);
      end
      tick();
      i_dmem_ack = 1'b0;
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data, o_bus_err, o_wb_RegWrite} !== {1'b1, 32'hCAFE_F00D, 2'b01}) begin
         bad++; $display("FAIL ackto_wb got %b/%h/%b/%b want 1/cafef00d/0/1",
                         o_wb_valid, o_wb_data, o_bus_err, o_wb_RegWrite);
      end
      tick();
   endtask

   task automatic test_reset_busy();
      drive(1'b1, 32'h0000_0400, 32'h1234_5678, 5'd10, 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
      total++; if (o_dmem_req !== 1'b1) begin bad++; $display("FAIL rstb_req got %b want 1", o_dmem_req); end
      i_reset = 1'b1;
      i_valid = 1'b0;
      tick();
      i_reset = 1'b0;
      i_dmem_ack = 1'b1;
      #1;
      total++; if ({o_dmem_req, o_wb_valid, o_stall} !== 3'b000) begin
         bad++; $display("FAIL rstb_after got req=%b wbv=%b stall=%b want 0 0 0", o_dmem_req, o_wb_valid, o_stall);
      end
      tick();
      i_dmem_ack = 1'b0;
      total++; if ({o_dmem_req, o_wb_valid} !== 2'b00) begin
         bad++; $display("FAIL rstb_ack_ignored got req=%b wbv=%b want 0 0", o_dmem_req, o_wb_valid);
      end
      drive(1'b1, 32'h77, 32'h0, 5'd11, 1'b0, 1'b0, 3'd0, 1'b1);
      #1;
      total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rstb_idle_stall got %b want 0", o_stall); end
      tick();
      i_valid = 1'b0;
      total++; if ({o_wb_valid, o_wb_data} !== {1'b1, 32'h77}) begin
         bad++; $display("FAIL rstb_idle_wb got %b/%h want 1/00000077", o_wb_valid, o_wb_data);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_sb();
      test_load("lb",  32'h0000_0202, 3'd0, 32'h0080_0000, 32'hFFFF_FF80);
      test_load("lbu", 32'h0000_0202, 3'd4, 32'h0080_0000, 32'h0000_0080);
      test_load("lh",  32'h0000_0102, 3'd1, 32'h8001_0000, 32'hFFFF_8001);
      test_load("lhu", 32'h0000_0102, 3'd5, 32'h8001_0000, 32'h0000_8001);
      test_load("lw",  32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      test_lw_misaligned();
      test_timeout();
      test_ack_at_timeout();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule
